// File: rtl/instr_fetch.sv
// Instruction fetch: holds PC, issues in-order imem reads, buffers {pc, instr} for decode.
// Latency: instr visible to decode one clk after its imem response; 1 instr/clk with 1-cycle memory.
// Backpressure: requests stop when outstanding + buffered reach FIFO_DEPTH. Option: INSTR_FETCH_MISALIGN_CHK_EN.

module instr_fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    input  logic                   flush,
    output logic [WIDTH-1:0]       rdata,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;

    assign rdata = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= wdata;
    end
endmodule

module instr_fetch #(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            if_valid,
    output logic [31:0]     if_instr,
    output logic [XLEN-1:0] if_pc,
    output logic [6:0]      if_opcode,
`ifdef INSTR_FETCH_MISALIGN_CHK_EN
    output logic            if_misalign,
`endif
    input  logic            if_ready
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int DW = XLEN + 32;

    localparam logic [1:0] ST_BOOT  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    logic [1:0]      state;
    logic [XLEN-1:0] pc;
    logic [CW-1:0]   drop_cnt;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   buf_cnt;
    logic [CW:0]     credits_used;
    logic [CW-1:0]   inflight_next;
    logic [XLEN-1:0] tag_head;
    logic [DW-1:0]   head;
    logic [XLEN-1:0] fetch_target;
    logic            halt;
    logic            rsp_ok;
    logic            pop;
    logic            accept;
    logic            push;

`ifdef INSTR_FETCH_MISALIGN_CHK_EN
    logic misalign;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign <= 1'b0;
        end else if (redirect_valid) begin
            misalign <= (redirect_pc[1:0] != 2'b00);
        end
    end

    assign halt         = misalign;
    assign if_misalign  = misalign;
    assign fetch_target = redirect_pc;
`else
    assign halt         = 1'b0;
    assign fetch_target = redirect_pc & ~XLEN'(3);
`endif

    // Responses with no matching request (e.g. issued before a reset) are ignored.
    assign rsp_ok = imem_rsp_valid && (outstanding != '0);
    assign pop    = if_valid && if_ready;

    // A same-cycle pop frees a credit so a single-cycle memory sustains 1 instr/clk.
    assign credits_used   = {1'b0, outstanding} + {1'b0, buf_cnt} - (CW+1)'(pop);
    assign imem_req_valid = (state == ST_RUN) && !redirect_valid && !halt &&
                            (credits_used < (CW+1)'(FIFO_DEPTH));
    assign imem_req_addr  = pc;
    assign accept         = imem_req_valid && imem_req_ready;
    assign push           = rsp_ok && (drop_cnt == '0) && !redirect_valid;
    assign inflight_next  = outstanding + CW'(accept) - CW'(rsp_ok);

    assign if_valid  = (buf_cnt != '0) && !halt;
    assign if_instr  = if_valid ? head[31:0] : 32'd0;
    assign if_pc     = if_valid ? head[DW-1:32] : '0;
    assign if_opcode = if_instr[6:0];

    instr_fetch_fifo #(.WIDTH(XLEN), .DEPTH(FIFO_DEPTH)) u_tag_q (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (accept),
        .wdata (pc),
        .pop   (rsp_ok),
        .flush (1'b0),
        .rdata (tag_head),
        .count (outstanding)
    );

    instr_fetch_fifo #(.WIDTH(DW), .DEPTH(FIFO_DEPTH)) u_rsp_q (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata ({tag_head, imem_rsp_data}),
        .pop   (pop),
        .flush (redirect_valid),
        .rdata (head),
        .count (buf_cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_BOOT;
            pc       <= RESET_PC;
            drop_cnt <= '0;
        end else begin
            if (redirect_valid) begin
                pc <= fetch_target;
            end else if (accept) begin
                pc <= pc + XLEN'(4);
            end

            // Everything still in flight at a redirect belongs to the old path.
            if (redirect_valid) begin
                drop_cnt <= inflight_next;
            end else if (rsp_ok && (drop_cnt != '0)) begin
                drop_cnt <= drop_cnt - CW'(1);
            end

            case (state)
                ST_BOOT:  state <= ST_RUN;
                ST_RUN:   if (redirect_valid && (inflight_next != '0)) state <= ST_FLUSH;
                ST_FLUSH: if (drop_cnt == '0) state <= ST_RUN;
                default:  state <= ST_BOOT;
            endcase
        end
    end
endmodule
